// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program memory responder.
// Holds the LOAD/RUN state enum, the reset instruction and default geometry.
package prog_mem_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          DEF_ADDR_W = 6;
    localparam int          DEF_DATA_W = 32;

endpackage

// File: rtl/prog_mem_array.sv
// Storage array: 2^ADDR_W x WORD_W, one synchronous write port, one synchronous read port.
// Read data appears one cycle after re_i and holds until the next read; contents are never reset.
module prog_mem_array #(
    parameter int ADDR_W = 6,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem.sv
// Program memory: boot-loads over valid/ready, then serves PC fetches with 1-cycle latency.
// Loader is stalled (ld_ready=0) outside LOAD; optional parity via PROG_MEM_PARITY_EN.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] adr_in,
    input  logic              rd_req,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload,
`ifdef PROG_MEM_PARITY_EN
    output logic              par_err,
    input  logic              par_inject,
`endif
    output logic              boot_done
);

`ifdef PROG_MEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int                WORD_W   = DATA_W + PAR_W;
    localparam logic [ADDR_W-1:0] WPTR_TOP = '1;
    localparam logic [DATA_W-1:0] NOP_W    = DATA_W'(NOP_INSTR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              valid_q, valid_d;
    logic              served_q, served_d;

    logic              wr_en;
    logic              rd_en;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    // Writes and fetches are exclusive by state, so the array never sees both at once.
    assign wr_en = (state_q == ST_LOAD) && ld_valid;
    assign rd_en = (state_q == ST_RUN) && ce && rd_req;

`ifdef PROG_MEM_PARITY_EN
    assign wr_word = {(^ld_data) ^ par_inject, ld_data};
`else
    assign wr_word = ld_data;
`endif

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        valid_d  = rd_en;
        served_d = served_q | rd_en;
        case (state_q)
            ST_LOAD: begin
                if (wr_en) begin
                    if (ld_last || (wptr_q == WPTR_TOP)) begin
                        state_d = ST_RUN;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_d = ST_LOAD;
                    wptr_d  = '0;
                end
            end
            default: begin
                state_d = ST_LOAD;
                wptr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            wptr_q   <= '0;
            valid_q  <= 1'b0;
            served_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            valid_q  <= valid_d;
            served_q <= served_d;
        end
    end

    prog_mem_array #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wptr_q),
        .wdata_i (wr_word),
        .re_i    (rd_en),
        .raddr_i (adr_in),
        .rdata_o (rd_word)
    );

    // The array read register holds between fetches; until the first fetch since reset show NOP.
    assign instr_out   = served_q ? rd_word[DATA_W-1:0] : NOP_W;
    assign instr_valid = valid_q;
    assign ld_ready    = (state_q == ST_LOAD);
    assign boot_done   = (state_q == ST_RUN);

`ifdef PROG_MEM_PARITY_EN
    assign par_err = valid_q & (^rd_word);
`endif

endmodule
